// File: rtl/acc_mode_controller.sv
// acc_mode_controller: supervisory ACC mode FSM with set-speed latch, sensor
// timeout fault, and slew-limited, state-gated throttle/brake commands.
//
// Optional feature macro: ACC_RESUME_EN
//   defined   - a driver_resume rising edge in STANDBY re-engages ACTIVE with
//               the stored set_speed (set edge wins if both occur together)
//   undefined - driver_resume is ignored
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-low reset (0 = reset)
//   acc_on         ACC main switch level
//   driver_set     set button level (rising edge detected internally)
//   driver_cancel  cancel button level
//   driver_resume  resume button level (used only with ACC_RESUME_EN)
//   brake_pedal    driver brake applied
//   accel_pedal    driver accelerator applied
//   sensor_valid   radar/lead data valid this cycle
//   vehicle_speed  current ego speed, unsigned
//   throttle_in    throttle request from pipeline
//   brake_in       brake request from pipeline
//   acc_state      0 OFF, 1 STANDBY, 2 ACTIVE, 3 OVERRIDE, 4 FAULT
//   pipe_enable    pipeline run enable (ACTIVE or OVERRIDE)
//   set_speed      latched target speed
//   throttle_cmd   gated, slew-limited throttle to actuator
//   brake_cmd      gated brake to actuator
//   fault          high while in FAULT
module acc_mode_controller #(
    parameter int unsigned MIN_ENGAGE_SPEED = 30,
    parameter int unsigned SENSOR_TIMEOUT   = 8,
    parameter int unsigned RAMP_STEP        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        acc_on,
    input  logic        driver_set,
    input  logic        driver_cancel,
    input  logic        driver_resume,
    input  logic        brake_pedal,
    input  logic        accel_pedal,
    input  logic        sensor_valid,
    input  logic [15:0] vehicle_speed,
    input  logic [7:0]  throttle_in,
    input  logic [7:0]  brake_in,
    output logic [2:0]  acc_state,
    output logic        pipe_enable,
    output logic [15:0] set_speed,
    output logic [7:0]  throttle_cmd,
    output logic [7:0]  brake_cmd,
    output logic        fault
);

    localparam int TW = $clog2(SENSOR_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(SENSOR_TIMEOUT);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_STANDBY  = 3'd1,
        S_ACTIVE   = 3'd2,
        S_OVERRIDE = 3'd3,
        S_FAULT    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic          set_prev_q;
    logic [15:0]   set_speed_q, set_speed_d;
    logic [7:0]    throttle_cmd_q, throttle_cmd_d;
    logic [7:0]    brake_cmd_q, brake_cmd_d;
    logic          pipe_enable_q, pipe_enable_d;
    logic          fault_q, fault_d;

    logic          set_edge, engage_ok, set_go, resume_go, timeout_hit;
    logic [8:0]    ramp_sum;
    logic [7:0]    ramp_lim, throttle_next;

    // Engagement needs speed, valid data and no cancel (cancel beats set/resume)
    assign set_edge    = driver_set & ~set_prev_q;
    assign engage_ok   = (vehicle_speed >= 16'(MIN_ENGAGE_SPEED)) & sensor_valid & ~driver_cancel;
    assign set_go      = set_edge & engage_ok;
    // Fault fires on the edge where the counter reaches the limit
    assign timeout_d   = sensor_valid ? '0 : (timeout_q == TMAX ? timeout_q : timeout_q + TW'(1));
    assign timeout_hit = timeout_d == TMAX;

`ifdef ACC_RESUME_EN
    logic resume_prev_q;
    always_ff @(posedge clk) begin
        if (!reset) resume_prev_q <= 1'b0;
        else        resume_prev_q <= driver_resume;
    end
    assign resume_go = driver_resume & ~resume_prev_q & engage_ok & (set_speed_q != 16'd0);
`else
    logic unused_resume;
    assign unused_resume = driver_resume;
    assign resume_go     = 1'b0;
`endif

    // State register and all output flops
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_OFF;
            timeout_q      <= '0;
            set_prev_q     <= 1'b0;
            set_speed_q    <= '0;
            throttle_cmd_q <= '0;
            brake_cmd_q    <= '0;
            pipe_enable_q  <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timeout_q      <= timeout_d;
            set_prev_q     <= driver_set;
            set_speed_q    <= set_speed_d;
            throttle_cmd_q <= throttle_cmd_d;
            brake_cmd_q    <= brake_cmd_d;
            pipe_enable_q  <= pipe_enable_d;
            fault_q        <= fault_d;
        end
    end

    // Next-state logic, including the set-speed latch
    always_comb begin
        state_d     = state_q;
        set_speed_d = set_speed_q;
        if (!acc_on) begin
            state_d     = S_OFF;
            set_speed_d = '0;
        end else begin
            case (state_q)
                S_OFF:     state_d = S_STANDBY;
                S_STANDBY: begin
                    if (set_go) begin
                        state_d     = S_ACTIVE;
                        set_speed_d = vehicle_speed;
                    end else if (resume_go) begin
                        state_d = S_ACTIVE;
                    end
                end
                S_ACTIVE:   state_d = timeout_hit ? S_FAULT :
                                      (brake_pedal | driver_cancel) ? S_STANDBY :
                                      accel_pedal ? S_OVERRIDE : S_ACTIVE;
                S_OVERRIDE: state_d = timeout_hit ? S_FAULT :
                                      (brake_pedal | driver_cancel) ? S_STANDBY :
                                      accel_pedal ? S_OVERRIDE : S_ACTIVE;
                S_FAULT:    state_d = S_FAULT;
                default:    state_d = S_OFF;
            endcase
        end
    end

    // Outputs are gated by the next state so they line up with acc_state
    always_comb begin
        ramp_sum       = {1'b0, throttle_cmd_q} + 9'(RAMP_STEP);
        ramp_lim       = ramp_sum[8] ? 8'hFF : ramp_sum[7:0];
        throttle_next  = (throttle_in > throttle_cmd_q) ?
                         ((throttle_in < ramp_lim) ? throttle_in : ramp_lim) : throttle_in;
        throttle_cmd_d = (state_d == S_ACTIVE) ? throttle_next : 8'd0;
        brake_cmd_d    = (state_d == S_ACTIVE) ? brake_in : 8'd0;
        pipe_enable_d  = (state_d == S_ACTIVE) || (state_d == S_OVERRIDE);
        fault_d        = state_d == S_FAULT;
    end

    assign acc_state    = state_q;
    assign pipe_enable  = pipe_enable_q;
    assign set_speed    = set_speed_q;
    assign throttle_cmd = throttle_cmd_q;
    assign brake_cmd    = brake_cmd_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_acc_mode_controller.sv
// tb_acc_mode_controller: directed self-checking bench for acc_mode_controller.
module tb_acc_mode_controller;

    logic        clk = 1'b0;
    logic        reset, acc_on, driver_set, driver_cancel, driver_resume;
    logic        brake_pedal, accel_pedal, sensor_valid;
    logic [15:0] vehicle_speed;
    logic [7:0]  throttle_in, brake_in;
    logic [2:0]  acc_state;
    logic        pipe_enable, fault;
    logic [15:0] set_speed;
    logic [7:0]  throttle_cmd, brake_cmd;

    int errors = 0;
    int checks = 0;

    acc_mode_controller dut (
        .clk(clk), .reset(reset), .acc_on(acc_on), .driver_set(driver_set),
        .driver_cancel(driver_cancel), .driver_resume(driver_resume),
        .brake_pedal(brake_pedal), .accel_pedal(accel_pedal),
        .sensor_valid(sensor_valid), .vehicle_speed(vehicle_speed),
        .throttle_in(throttle_in), .brake_in(brake_in), .acc_state(acc_state),
        .pipe_enable(pipe_enable), .set_speed(set_speed),
        .throttle_cmd(throttle_cmd), .brake_cmd(brake_cmd), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [15:0] exp_spd;
        reset = 0; acc_on = 0; driver_set = 0; driver_cancel = 0; driver_resume = 0;
        brake_pedal = 0; accel_pedal = 0; sensor_valid = 1; vehicle_speed = 60;
        throttle_in = 0; brake_in = 0;
        step(2);
        check("rst_state", acc_state, 0);
        check("rst_pipe", pipe_enable, 0);
        check("rst_speed", set_speed, 0);
        check("rst_thr", throttle_cmd, 0);
        check("rst_brk", brake_cmd, 0);
        check("rst_fault", fault, 0);

        // engage
        reset = 1; acc_on = 1;
        step();
        check("standby", acc_state, 1);
        driver_set = 1;
        step();
        driver_set = 0;
        check("engage_state", acc_state, 2);
        check("engage_speed", set_speed, 60);
        check("engage_pipe", pipe_enable, 1);

        // throttle ramp and immediate decrease, brake pass-through
        throttle_in = 10;
        step(); check("ramp4", throttle_cmd, 4);
        step(); check("ramp8", throttle_cmd, 8);
        step(); check("ramp10", throttle_cmd, 10);
        throttle_in = 3;
        step(); check("thr_drop", throttle_cmd, 3);
        brake_in = 20;
        step(); check("brk_pass", brake_cmd, 20);

        // override: outputs gated, release ramps from zero
        throttle_in = 10; accel_pedal = 1;
        step();
        check("ovr_state", acc_state, 3);
        check("ovr_thr", throttle_cmd, 0);
        check("ovr_brk", brake_cmd, 0);
        check("ovr_pipe", pipe_enable, 1);
        accel_pedal = 0;
        step();
        check("ovr_rel_state", acc_state, 2);
        check("ovr_rel_thr", throttle_cmd, 4);
        check("ovr_rel_brk", brake_cmd, 20);
        brake_pedal = 1;
        step();
        brake_pedal = 0;
        check("brake_state", acc_state, 1);
        check("brake_speed", set_speed, 60);
        check("brake_pipe", pipe_enable, 0);
        check("brake_thr", throttle_cmd, 0);

        // low speed and set+cancel priority
        vehicle_speed = 20; driver_set = 1;
        step(); check("low_speed", acc_state, 1);
        driver_set = 0; step();
        vehicle_speed = 60; driver_set = 1; driver_cancel = 1;
        step(); check("set_cancel", acc_state, 1);
        driver_set = 0; driver_cancel = 0; step();

        // dropped edge does not retrigger while held; exact threshold engages
        vehicle_speed = 29; driver_set = 1;
        step(); check("spd29", acc_state, 1);
        vehicle_speed = 30;
        step(); check("held_no_retrig", acc_state, 1);
        driver_set = 0; step();
        driver_set = 1;
        step(); check("spd30_state", acc_state, 2);
        check("spd30_speed", set_speed, 30);
        driver_set = 0; vehicle_speed = 60; brake_pedal = 1;
        step(); brake_pedal = 0;
        check("brake2_state", acc_state, 1);

        // resume
        driver_resume = 1;
        step();
        driver_resume = 0;
`ifdef ACC_RESUME_EN
        check("resume_state", acc_state, 2);
        check("resume_speed", set_speed, 30);
        exp_spd = 30;
`else
        check("resume_ignored", acc_state, 1);
        check("resume_speed", set_speed, 30);
        exp_spd = 60;
`endif
        driver_set = 1;
        step();
        driver_set = 0;
        check("active_again", acc_state, 2);
        check("active_speed", set_speed, exp_spd);

        // 7-cycle dropout must not fault, 8 must
        throttle_in = 10;
        sensor_valid = 0;
        step(7);
        check("drop7_state", acc_state, 2);
        sensor_valid = 1;
        step(); check("drop7_recover", acc_state, 2);
        sensor_valid = 0;
        step(7); check("drop_pre", acc_state, 2);
        step();
        check("fault_state", acc_state, 4);
        check("fault_flag", fault, 1);
        check("fault_pipe", pipe_enable, 0);
        check("fault_thr", throttle_cmd, 0);
        check("fault_brk", brake_cmd, 0);
        sensor_valid = 1;
        step(); check("fault_sticky", acc_state, 4);
        acc_on = 0;
        step();
        check("off_state", acc_state, 0);
        check("off_speed", set_speed, 0);
        check("off_fault", fault, 0);

        // reset mid-operation
        acc_on = 1; step();
        driver_set = 1; step();
        check("re_engage", acc_state, 2);
        reset = 0;
        step();
        check("midrst_state", acc_state, 0);
        check("midrst_speed", set_speed, 0);
        check("midrst_thr", throttle_cmd, 0);
        check("midrst_brk", brake_cmd, 0);
        check("midrst_pipe", pipe_enable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
